// File: rtl/parking_lot_detector_pkg.sv
// Shared types for the parking-lot gate detector: FSM states and sensor codes.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_AB = 3'd5,
        EX_A  = 3'd6,
        FAULT = 3'd7
    } state_t;

    // Sensor codes are {a,b}: a is the outer beam, b the inner beam.
    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_A    = 2'b10;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_AB   = 2'b11;

endpackage

// File: rtl/parking_lot_detector_if.sv
// Gate-side signal bundle: sensor levels in, event pulses and occupancy out.
interface parking_lot_detector_if #(parameter int CNT_W = 4);
    import parking_pkg::*;

    // a/b are plain levels sampled on every clk edge (no valid/ready); all outputs are registered or derived from registered count.
    logic             a;
    logic             b;
    logic             enter;
    logic             exit;
    logic             err;
    logic             ovf;
    logic             unf;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    state_t           state;

    modport master (
        output a, b,
        input  enter, exit, err, ovf, unf, count, full, empty, state
    );

    modport slave (
        input  a, b,
        output enter, exit, err, ovf, unf, count, full, empty, state
    );

endinterface

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter with overflow/underflow pulses.
module occupancy_counter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (inc) begin
                if (count == CAP) ovf <= 1'b1;
                else              count <= count + 1'b1;
            end else if (dec) begin
                if (count == '0) unf <= 1'b1;
                else             count <= count - 1'b1;
            end
        end
    end

    assign full  = (count == CAP);
    assign empty = (count == '0);

endmodule

// File: rtl/parking_lot_detector.sv
// Decodes outer/inner beam-break sequences into entry/exit events and tracks occupancy.
module parking_lot_detector
    import parking_pkg::*;
#(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    parking_lot_detector_if.slave  bus
);

    state_t     state, next_state;
    logic [1:0] ab;
    logic       entry_evt, exit_evt;
    logic       enter_q, exit_q, err_q;

    assign ab = {bus.a, bus.b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= next_state;
            enter_q <= entry_evt;
            exit_q  <= exit_evt;
            // err only on the way into FAULT, never while parked there
            err_q   <= (next_state == FAULT) && (state != FAULT);
        end
    end

    always_comb begin
        next_state = state;
        entry_evt  = 1'b0;
        exit_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (ab == S_A)       next_state = EN_A;
                else if (ab == S_B)  next_state = EX_B;
                else if (ab == S_AB) next_state = FAULT;
            end
            EN_A: begin
                if (ab == S_AB)        next_state = EN_AB;
                else if (ab == S_NONE) next_state = IDLE;
                else if (ab == S_B)    next_state = FAULT;
            end
            EN_AB: begin
                if (ab == S_B)         next_state = EN_B;
                else if (ab == S_A)    next_state = EN_A;
                else if (ab == S_NONE) next_state = FAULT;
            end
            EN_B: begin
                if (ab == S_NONE) begin
                    next_state = IDLE;
                    entry_evt  = 1'b1;
                end
                else if (ab == S_AB) next_state = EN_AB;
                else if (ab == S_A)  next_state = FAULT;
            end
            EX_B: begin
                if (ab == S_AB)        next_state = EX_AB;
                else if (ab == S_NONE) next_state = IDLE;
                else if (ab == S_A)    next_state = FAULT;
            end
            EX_AB: begin
                if (ab == S_A)         next_state = EX_A;
                else if (ab == S_B)    next_state = EX_B;
                else if (ab == S_NONE) next_state = FAULT;
            end
            EX_A: begin
                if (ab == S_NONE) begin
                    next_state = IDLE;
                    exit_evt   = 1'b1;
                end
                else if (ab == S_AB) next_state = EX_AB;
                else if (ab == S_B)  next_state = FAULT;
            end
            FAULT: begin
                if (ab == S_NONE) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    occupancy_counter #(
        .CAPACITY(CAPACITY),
        .CNT_W   (CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (entry_evt),
        .dec  (exit_evt),
        .count(bus.count),
        .full (bus.full),
        .empty(bus.empty),
        .ovf  (bus.ovf),
        .unf  (bus.unf)
    );

    assign bus.enter = enter_q;
    assign bus.exit  = exit_q;
    assign bus.err   = err_q;
    assign bus.state = state;

endmodule

// File: doc/parking_lot_detector.md
Name: parking_lot_detector

Overview:
- Consumes two debounced photo-sensor levels at the lot gate: `a` is the outer beam, `b` is the inner beam.
- Decodes the beam-break sequence into car-entered and car-exited events.
- Keeps a saturating occupancy count with full/empty flags.
- Sits downstream of the per-sensor button/sensor debouncers and upstream of the seven-segment and LED display logic.

Parameters:
- CAPACITY, 8, number of spaces in the lot; the count saturates at this value.
- CNT_W, 4, width of the count output; must satisfy 2**CNT_W > CAPACITY.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- a  input  1  debounced outer sensor, 1 = beam blocked; synchronous to clk
- b  input  1  debounced inner sensor, 1 = beam blocked; synchronous to clk
- enter  output  1  one-cycle pulse when a car completes entry
- exit  output  1  one-cycle pulse when a car completes exit
- err  output  1  one-cycle pulse on an illegal sensor transition
- ovf  output  1  one-cycle pulse when an entry completes while count == CAPACITY
- unf  output  1  one-cycle pulse when an exit completes while count == 0
- count  output  CNT_W  current occupancy
- full  output  1  count == CAPACITY (combinational from count)
- empty  output  1  count == 0 (combinational from count)

Behaviour:
- Reset (asynchronous): state = IDLE, count = 0, and enter/exit/err/ovf/unf = 0. After reset, empty = 1 and full = 0.
- Inputs `{a,b}` are sampled every clk edge; there is no internal synchronizer.
- All pulse outputs are registered and high for exactly one cycle. They are asserted in the cycle after the edge at which the completing `{a,b}` value was sampled.
- count updates on the same edge, so it is visible in the same cycle as the pulse.
- State transitions, by current state and sampled `{a,b}`. An unlisted value keeps the current state.
  - IDLE: 10 -> EN_A; 01 -> EX_B; 11 -> FAULT.
  - EN_A: 11 -> EN_AB; 00 -> IDLE (abort, no event); 01 -> FAULT.
  - EN_AB: 01 -> EN_B; 10 -> EN_A (car backing out); 00 -> FAULT.
  - EN_B: 00 -> IDLE plus entry event; 11 -> EN_AB; 10 -> FAULT.
  - EX_B: 11 -> EX_AB; 00 -> IDLE (abort); 10 -> FAULT.
  - EX_AB: 10 -> EX_A; 01 -> EX_B; 00 -> FAULT.
  - EX_A: 00 -> IDLE plus exit event; 11 -> EX_AB; 01 -> FAULT.
  - FAULT: 00 -> IDLE; any other value stays in FAULT.
- err pulses once, on the transition into FAULT only. It does not repeat while the block remains in FAULT.
- Entry event:
  - If count < CAPACITY: count increments and enter pulses.
  - If count == CAPACITY: count holds, and both enter and ovf pulse.
- Exit event:
  - If count > 0: count decrements and exit pulses.
  - If count == 0: count holds, and both exit and unf pulse.
- Entry and exit events are mutually exclusive by construction, so there is no simultaneous-update case.
- Reset asserted mid-sequence aborts the sequence. No event is generated and the count returns to 0.
- Back-and-forth oscillation, e.g. EN_AB <-> EN_B repeated, generates no events until the block finally reaches IDLE with 00.
- Arithmetic is unsigned CNT_W-bit. Wrap-around is impossible because of saturation.

Decomposition:
- Package `parking_pkg`: the state enum (IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, FAULT) and the sensor-code constants (S_NONE=2'b00, S_A=2'b10, S_B=2'b01, S_AB=2'b11).
- Sub-module `occupancy_counter`:
  - Parameters: CAPACITY, CNT_W.
  - Inputs: inc, dec.
  - Outputs: count, full, empty, ovf, unf.
  - Behaviour: saturating up/down counter with asynchronous reset.
- The top level holds the FSM and the registered enter/exit/err pulses.

Test Plan:
- Entry: from reset, drive `{a,b}` = 00,10,11,01,00, holding each value for 3 cycles -> enter high for exactly 1 cycle, one cycle after 00 is sampled; count 0 -> 1; empty falls; err stays 0.
- Exit: at count = 1, drive 00,01,11,10,00 -> exit pulses once; count 1 -> 0; empty = 1.
- Abort/back-up: drive 10,11,10,00 -> no enter, exit or err; count unchanged. Also drive 10,11,01,11,01,00 -> exactly one enter.
- Illegal: from IDLE drive 11 for 5 cycles, then 00 -> err high for 1 cycle only; state returns to IDLE; count unchanged. Follow with a normal entry -> counts correctly.
- Saturation: 9 entries with CAPACITY = 8 -> count = 8, full = 1, and on the 9th entry enter and ovf pulse together while count stays 8. Then 9 exits -> count = 0, and unf pulses on the 9th exit.
- Reset mid-sequence: at count = 3, drive 10,11, then assert reset for 2 cycles -> count = 0, all pulses 0. Then drive 01,00 after reset releases -> enter stays 0 (IDLE goes to EX_B and aborts).
